// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end fetch stage feeding the decoder.
//
// Owns the fetch PC, issues one word read at a time to instruction memory,
// buffers returned words in a QDEPTH-entry queue and presents the head to
// decode with a valid/ready handshake, tagged with its PC. Decode reports
// jumps and taken branches back; the block flushes the queue, discards any
// in-flight wrong-path response and refetches from the computed target.
//
// Parameters:
//   RESET_PC  PC loaded on reset (word aligned)
//   QDEPTH    queue entries, power of two, 2..8
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   imem_req, imem_addr               read request / word-aligned byte address
//   imem_rvalid, imem_rdata           in-order read response
//   instr_valid, instr, instr_pc      queue head (registered)
//   instr_ready                       decode accepts head this cycle
//   jump, branch_taken, br_pc,
//   adr, imm                          redirect reported by decode
//
// Optional build macro FETCH_PERF_CNT_EN adds fetch_count (queue pushes)
// and flush_count (redirect cycles) outputs.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [31:0] br_pc,
    input  logic [25:0] adr,
    input  logic [15:0] imm
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
`endif
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_t          state, state_n;
    logic [31:0]     fetch_pc;
    logic [31:0]     req_pc;      // address of the outstanding request
    entry_t          q [QDEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, rd_next;
    logic [CW-1:0]   count;

    logic            redirect;
    logic [31:0]     seq_pc, br_target, target;
    logic            push, pop;
    logic            head_from_push, load_head;
    entry_t          head_n;

    // Redirect target; jump wins when both are reported.
    assign redirect  = jump | branch_taken;
    assign seq_pc    = br_pc + 32'd4;
    assign br_target = seq_pc + {{14{imm[15]}}, imm, 2'b00};
    assign target    = jump ? {seq_pc[31:28], adr, 2'b00} : br_target;

    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);

    // A redirect cycle neither pushes nor pops. Responses landing in DROP
    // are wrong-path and never reach the queue.
    assign push = (state == WAIT) && imem_rvalid && !redirect;
    assign pop  = instr_valid && instr_ready && !redirect;

    // Head register update: a freshly pushed word becomes head only when it
    // lands in an empty queue (or the sole entry is popped the same cycle);
    // otherwise the new head is already sitting in storage.
    always_comb begin
        rd_next        = pop ? rd_ptr + PW'(1) : rd_ptr;
        head_from_push = push && ((count == '0) || (pop && count == CW'(1)));
        load_head      = head_from_push || (pop && count > CW'(1));
        head_n         = head_from_push ? '{word: imem_rdata, pc: req_pc} : q[rd_next];
    end

    // Request/response FSM. Only one request is ever outstanding, so a
    // single free slot is enough to issue.
    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && !redirect && count < CW'(QDEPTH)) begin
                    imem_req = 1'b1;
                    state_n  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid)
                    state_n = IDLE;
                else if (redirect)
                    state_n = DROP;
            end
            DROP: begin
                if (imem_rvalid)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            state <= state_n;
            if (redirect)
                fetch_pc <= target;
            else if (imem_req)
                fetch_pc <= fetch_pc + 32'd4;
            if (imem_req)
                req_pc <= fetch_pc;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                rd_ptr <= rd_next;
                count  <= count + CW'(push) - CW'(pop);
                if (load_head) begin
                    instr    <= head_n.word;
                    instr_pc <= head_n.pc;
                end
            end
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push)
            q[wr_ptr] <= '{word: imem_rdata, pc: req_pc};
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push)
                fetch_count <= fetch_count + 32'd1;
            if (redirect)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a directed vector table for the key
// scenarios, then randomized traffic against a behavioural model of the
// fetch stream (memory with random latency, redirects, backpressure and
// mid-run resets).
module tb_instruction_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          QD  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        jump;
    logic        branch_taken;
    logic [31:0] br_pc;
    logic [25:0] adr;
    logic [15:0] imm;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    instruction_fetch #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .jump(jump), .branch_taken(branch_taken), .br_pc(br_pc),
        .adr(adr), .imm(imm)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;

    // Memory / reference model state
    logic        busy, live;
    int          lat;
    logic [31:0] mem_addr;
    int          occ;
    logic [31:0] exp_pc, exp_req;
    int          nfetch, nflush, npops;

    typedef struct {
        logic        rdy, jmp, bt;
        logic [31:0] bpc;
        logic [25:0] a;
        logic [15:0] im;
        logic        rv;
        logic [31:0] rd;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] ei, epc;
    } vec_t;
    vec_t tv[$];

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h1357_0000;
    endfunction

    function automatic logic [31:0] tgt(input logic j, input logic [31:0] bpc,
                                        input logic [25:0] a, input logic [15:0] im);
        logic [31:0] s;
        s = bpc + 32'd4;
        if (j) return (s & 32'hF000_0000) | ({6'd0, a} << 2);
        return s + 32'($signed(im)) * 32'd4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic row(input logic rdy, jmp, bt, input logic [31:0] bpc, input logic [25:0] a,
                       input logic [15:0] im, input logic rv, input logic [31:0] rd,
                       input logic ereq, input logic [31:0] eaddr, input logic evld,
                       input logic [31:0] ei, epc);
        vec_t v;
        v.rdy = rdy; v.jmp = jmp; v.bt = bt; v.bpc = bpc; v.a = a; v.im = im;
        v.rv = rv; v.rd = rd; v.ereq = ereq; v.eaddr = eaddr; v.evld = evld;
        v.ei = ei; v.epc = epc;
        tv.push_back(v);
    endtask

    task automatic model_reset();
        busy = 0; live = 0; lat = 0; occ = 0;
        exp_pc = RPC; exp_req = RPC;
        nfetch = 0; nflush = 0;
        imem_rvalid = 0;
    endtask

    // Two-cycle reset; outputs are checked while reset is still asserted.
    task automatic do_reset();
        rst = 1; imem_rvalid = 0; jump = 0; branch_taken = 0; instr_ready = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        @(posedge clk); #1;
        rst = 0;
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fetch_count", fetch_count, 0);
        chk("rst_flush_count", flush_count, 0);
`endif
        model_reset();
    endtask

    initial begin
        logic        redir, rq_exp, req_s, push, pop;
        logic [31:0] addr_s, t;

        rst = 1; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;
        jump = 0; branch_taken = 0; br_pc = 0; adr = 0; imm = 0;

        // rdy jmp bt bpc adr imm rv rdata | req addr valid instr pc
        row(1,0,0,32'h0,26'h0,16'h0,0,32'h0,          1,32'h0,  0,32'h0,0);
        row(1,0,0,32'h0,26'h0,16'h0,1,32'h1357_0000,  0,32'h4,  0,32'h0,0);
        row(1,0,0,32'h0,26'h0,16'h0,0,32'h0,          1,32'h4,  1,32'h1357_0000,32'h0);
        row(1,0,0,32'h0,26'h0,16'h0,1,32'h1357_0004,  0,32'h8,  0,32'h1357_0000,32'h0);
        row(0,0,0,32'h0,26'h0,16'h0,0,32'h0,          1,32'h8,  1,32'h1357_0004,32'h4);
        row(0,0,0,32'h0,26'h0,16'h0,1,32'h1357_0008,  0,32'hC,  1,32'h1357_0004,32'h4);
        row(0,0,0,32'h0,26'h0,16'h0,0,32'h0,          0,32'hC,  1,32'h1357_0004,32'h4);
        row(0,0,0,32'h0,26'h0,16'h0,0,32'h0,          0,32'hC,  1,32'h1357_0004,32'h4);
        row(0,0,0,32'h0,26'h0,16'h0,0,32'h0,          0,32'hC,  1,32'h1357_0004,32'h4);
        row(1,0,0,32'h0,26'h0,16'h0,0,32'h0,          0,32'hC,  1,32'h1357_0004,32'h4);
        row(0,0,0,32'h0,26'h0,16'h0,0,32'h0,          1,32'hC,  1,32'h1357_0008,32'h8);
        row(1,0,1,32'h20,26'h0,16'hFFFE,0,32'h0,      0,32'h10, 1,32'h1357_0008,32'h8);
        row(1,0,0,32'h0,26'h0,16'h0,1,32'h1357_000C,  0,32'h1C, 0,32'h1357_0008,32'h8);
        row(1,0,0,32'h0,26'h0,16'h0,0,32'h0,          1,32'h1C, 0,32'h1357_0008,32'h8);
        row(1,0,0,32'h0,26'h0,16'h0,1,32'h1357_001C,  0,32'h20, 0,32'h1357_0008,32'h8);
        row(1,1,0,32'h10,26'h40,16'h0,0,32'h0,        0,32'h20, 1,32'h1357_001C,32'h1C);
        row(1,0,0,32'h0,26'h0,16'h0,0,32'h0,          1,32'h100,0,32'h1357_001C,32'h1C);
        row(1,1,1,32'h0,26'h3,16'h5,1,32'h1357_0100,  0,32'h104,0,32'h1357_001C,32'h1C);
        row(1,0,0,32'h0,26'h0,16'h0,0,32'h0,          1,32'hC,  0,32'h1357_001C,32'h1C);
        row(1,0,0,32'h0,26'h0,16'h0,1,32'h1357_000C,  0,32'h10, 0,32'h1357_001C,32'h1C);
        row(1,0,0,32'h0,26'h0,16'h0,0,32'h0,          1,32'h10, 1,32'h1357_000C,32'hC);
        row(1,0,0,32'h0,26'h0,16'h0,0,32'h0,          0,32'h14, 0,32'h1357_000C,32'hC);

        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            instr_ready = tv[i].rdy; jump = tv[i].jmp; branch_taken = tv[i].bt;
            br_pc = tv[i].bpc; adr = tv[i].a; imm = tv[i].im;
            imem_rvalid = tv[i].rv; imem_rdata = tv[i].rd;
            @(negedge clk);
            chk($sformatf("tv%0d req", i),   imem_req,    tv[i].ereq);
            chk($sformatf("tv%0d addr", i),  imem_addr,   tv[i].eaddr);
            chk($sformatf("tv%0d valid", i), instr_valid, tv[i].evld);
            chk($sformatf("tv%0d instr", i), instr,       tv[i].ei);
            chk($sformatf("tv%0d pc", i),    instr_pc,    tv[i].epc);
            @(posedge clk); #1;
        end

        // Randomized traffic against the stream model.
        do_reset();
        npops = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 1000 == 999) begin
                do_reset();
                continue;
            end
            instr_ready = ($urandom_range(0, 3) != 0);
            jump = 0; branch_taken = 0;
            br_pc = $urandom() & 32'hFFFF_FFFC;
            adr = 26'($urandom()); imm = 16'($urandom());
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 2))
                    0: jump = 1;
                    1: branch_taken = 1;
                    default: begin jump = 1; branch_taken = 1; end
                endcase
                // steer some redirects to the top of the address space
                if ($urandom_range(0, 3) == 0) begin
                    br_pc = 32'hFFFF_FFF0; adr = 26'h3FF_FFFF; imm = 16'h0002;
                end
            end
            redir = jump | branch_taken;
            t = tgt(jump, br_pc, adr, imm);

            @(negedge clk);
            req_s  = imem_req;
            addr_s = imem_addr;
            rq_exp = !busy && !imem_rvalid && (occ < QD) && !redir;
            chk("req", req_s, rq_exp);
            if (req_s) chk("req_addr", addr_s, exp_req);
            chk("valid", instr_valid, occ != 0);
            pop  = (occ != 0) && instr_ready && !redir;
            push = imem_rvalid && live && !redir;
            if (pop && instr_valid) begin
                chk("pop_pc", instr_pc, exp_pc);
                chk("pop_instr", instr, dat(exp_pc));
            end
            if (pop) begin occ--; exp_pc += 32'd4; npops++; end
            if (push) begin occ++; nfetch++; end
            if (imem_rvalid) live = 0;
            if (req_s) exp_req += 32'd4;
            if (redir) begin
                occ = 0; exp_pc = t; exp_req = t; live = 0; nflush++;
            end

            @(posedge clk); #1;
            imem_rvalid = 0;
            if (req_s) begin
                busy = 1; live = 1; mem_addr = addr_s;
                lat = ($urandom_range(0, 1) == 0) ? 1 : $urandom_range(2, 4);
            end
            if (busy) begin
                lat--;
                if (lat == 0) begin
                    imem_rvalid = 1; imem_rdata = dat(mem_addr); busy = 0;
                end
            end
        end
        chk("progress", npops > 200, 1);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, nfetch);
        chk("flush_count", flush_count, nflush);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end stage directly upstream of the instruction decoder. It owns the PC and issues word reads to instruction memory.
- Returned words are buffered in a small queue and presented to decode with a valid/ready handshake, each tagged with its PC.
- Decode reports jumps and taken branches back to this block. The block computes the target, flushes wrong-path words and refetches from the target.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- QDEPTH, 2, instruction queue entries; power of two, 2 to 8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  read request, valid for one cycle per fetch.
- imem_addr  output  32  byte address of the request; bits [1:0] are always 0.
- imem_rvalid  input  1  read data valid; arrives at least 1 cycle after imem_req; responses are in order.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  queue head is valid.
- instr  output  32  queue head instruction.
- instr_pc  output  32  PC of the queue head.
- instr_ready  input  1  decode accepts the head this cycle.
- jump  input  1  the instruction at br_pc is a j.
- branch_taken  input  1  the instruction at br_pc is a taken beq.
- br_pc  input  32  PC of the redirecting instruction.
- adr  input  26  jump target field.
- imm  input  16  branch offset field, in words.

Behaviour:
- Reset: fetch_pc=RESET_PC, queue empty, state IDLE. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- State machine (states IDLE, WAIT, DROP):
  - IDLE: when free slots exceed 0 (free slots = QDEPTH - count), drive imem_req=1 with imem_addr=fetch_pc, set fetch_pc+=4 and go to WAIT.
  - WAIT: on imem_rvalid, push {imem_rdata, issued addr} into the queue and go to IDLE.
  - At most one request is outstanding at any time.
  - Peak throughput is one word per 2 cycles with 1-cycle memory.
- Redirect: redirect = jump | branch_taken.
  - jump target = {br_pc+4 [31:28], adr, 2'b00}.
  - branch target = br_pc + 4 + ({{14{imm[15]}}, imm, 2'b00}); 32-bit arithmetic, wraps modulo 2^32.
  - jump has priority if both are asserted.
- On redirect, in the same edge:
  - Flush the queue (count=0) and set fetch_pc=target.
  - A redirect cycle never pushes and never pops; instr_ready that cycle is ignored.
  - Next state:
    - IDLE → IDLE: no request is issued in the redirect cycle; the first request goes to the target on the next cycle.
    - WAIT without rvalid → DROP.
    - WAIT with rvalid → IDLE; the word is discarded.
- DROP: issues no request. On imem_rvalid, discard the data and go to IDLE. A further redirect in DROP only updates fetch_pc.
- Queue:
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle is legal when full; count is unchanged.
  - Head outputs are registered from queue storage. instr and instr_pc hold their values when not popped.
  - When the queue is empty, instr and instr_pc keep their last value.
  - A pushed word is visible on instr_valid the cycle after imem_rvalid; there is no bypass.
- Free-slot check: when count == QDEPTH - 1 and no pop occurs, a request is still legal because no other request can be in flight.
- Wrap: fetch_pc 32'hFFFF_FFFC + 4 → 0.
- Reset mid-operation: a pending response is forgotten and any later imem_rvalid is ignored until the block's own next request. Memory is reset alongside.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count[31:0], incremented on each queue push.
  - Adds output flush_count[31:0], incremented on each redirect cycle.
  - Both counters clear on rst and wrap at 2^32.
- Undefined: neither port exists; no counter logic.

Test Plan:
1. Reset with RESET_PC=0, 1-cycle memory, instr_ready=1 → requests at 0,4,8,…; instr_pc follows 0,4,8 in order; imem_req never high on consecutive cycles.
2. instr_ready=0 for 10 cycles, QDEPTH=2 → exactly 2 words queued, no third request; raising instr_ready resumes fetch at 8.
3. jump=1, br_pc=32'h0000_0010, adr=26'h40 while idle → next imem_addr=32'h0000_0100; queue empty the next cycle.
4. branch_taken=1, br_pc=32'h20, imm=16'hFFFE while a request is outstanding → in-flight response dropped, no push; next request to 32'h1C.
5. branch_taken=1 and jump=1 together, adr=26'h3 → target 32'hC (jump wins).
6. With FETCH_PERF_CNT_EN: 5 fetches, 1 redirect → fetch_count=5, flush_count=1; after rst both read 0.
